// File: rtl/vm_seq_pkg.sv
// Shared types and constants for the sequential Vedic multiplier.
package vm_seq_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam int SLICE_W = 4;
  localparam int CORE_PW = 8;

  // Bit offset of the partial product for step k when each operand has kk slices.
  function automatic int slice_shift(input int k, input int kk);
    return SLICE_W * ((k % kk) + (k / kk));
  endfunction

endpackage

// File: rtl/vm_seq_mul_csa.sv
// VM_csa_opti: combinational 4x4 Vedic multiplier built from four 2x2 Vedic
// cells whose middle partial products are merged with a carry-save stage.
module VM_csa_opti (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic c1;
    logic [3:0] r;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c1   = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c1;
    r[3] = (x[1] & y[1]) & c1;
    return r;
  endfunction

  logic [3:0] w_q0, w_q1, w_q2, w_q3;
  logic [5:0] w_x, w_y, w_z, w_sum, w_carry;

  assign w_q0 = vedic2(i_a[1:0], i_b[1:0]);
  assign w_q1 = vedic2(i_a[3:2], i_b[1:0]);
  assign w_q2 = vedic2(i_a[1:0], i_b[3:2]);
  assign w_q3 = vedic2(i_a[3:2], i_b[3:2]);

  // Upper six product bits: {q3, q0[3:2]} + q1 + q2, reduced 3:2 then one add.
  assign w_x     = {w_q3, w_q0[3:2]};
  assign w_y     = {2'b00, w_q1};
  assign w_z     = {2'b00, w_q2};
  assign w_sum   = w_x ^ w_y ^ w_z;
  assign w_carry = {((w_x[4:0] & w_y[4:0]) | (w_x[4:0] & w_z[4:0]) | (w_y[4:0] & w_z[4:0])), 1'b0};

  assign o_p = {w_sum + w_carry, w_q0[1:0]};

endmodule

// File: rtl/vm_seq_mul.sv
// vm_seq_mul: WIDTH x WIDTH unsigned multiplier time-sharing one 4x4 Vedic core.
// Optional build macro VM_SEQ_ZERO_SKIP_EN: zero operands complete straight away.
module vm_seq_mul
  import vm_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int K       = WIDTH / SLICE_W;
  localparam int PROD_W  = 2 * WIDTH;
  localparam int N_STEPS = K * K;
  localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_STEPS - 1);

  if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 12 || WIDTH == 16)) begin : g_bad_width
    $error("vm_seq_mul: WIDTH must be 4, 8, 12 or 16");
  end

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_a, r_b;
  logic [PROD_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_accept, w_start_done;
  int                  w_i, w_j;
  logic [SLICE_W-1:0]  w_sa, w_sb;
  logic [CORE_PW-1:0]  w_core;
  logic [PROD_W-1:0]   w_term;

  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign in_ready = ~rst & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept = in_valid & in_ready;

`ifdef VM_SEQ_ZERO_SKIP_EN
  assign w_start_done = (a == '0) || (b == '0);
`else
  assign w_start_done = 1'b0;
`endif

  // Step k multiplies slice (k mod K) of a by slice (k div K) of b.
  always_comb begin
    w_i  = int'(r_cnt) % K;
    w_j  = int'(r_cnt) / K;
    w_sa = r_a[SLICE_W*w_i +: SLICE_W];
    w_sb = r_b[SLICE_W*w_j +: SLICE_W];
  end

  VM_csa_opti u_core (
    .i_a (w_sa),
    .i_b (w_sb),
    .o_p (w_core)
  );

  assign w_term = PROD_W'(w_core) << slice_shift(int'(r_cnt), K);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_start_done ? DONE : MUL;
      MUL:     if (r_cnt == LAST) w_state_nxt = DONE;
      DONE:    if (out_ready) begin
                 if (w_accept) w_state_nxt = w_start_done ? DONE : MUL;
                 else          w_state_nxt = IDLE;
               end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == MUL) begin
      r_acc <= r_acc + w_term;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == MUL) || (r_state == DONE);
  assign p         = r_acc;

endmodule

// File: tb/tb_vm_seq_mul.sv
// Self-checking bench for vm_seq_mul: directed vectors and corner sequences on
// WIDTH=8/16, plus randomized traffic on every legal WIDTH against a*b.
module tb_vm_seq_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

`ifdef VM_SEQ_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  localparam int N_RND  = 1000;
  localparam int BUDGET = 60000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed DUT, WIDTH=8 ----------------
  logic        d_rst = 1'b1;
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy;
  logic [7:0]  d_a, d_b;
  logic [15:0] d_p;

  vm_seq_mul #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .p(d_p), .busy(d_busy)
  );

  // ---------------- directed DUT, WIDTH=16 ----------------
  logic        e_rst = 1'b1;
  logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_busy;
  logic [15:0] e_a, e_b;
  logic [31:0] e_p;

  vm_seq_mul #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(e_rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .a(e_a), .b(e_b), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .p(e_p), .busy(e_busy)
  );

  // ---------------- random DUTs, every legal WIDTH ----------------
  logic r_rst = 1'b1;
  bit   rnd_done [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_rnd
    localparam int W = 4 * (gi + 1);
    logic           iv, ir, ov, ordy, bz;
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] rp;

    vm_seq_mul #(.WIDTH(W)) u_dut (
      .clk(clk), .rst(r_rst), .in_valid(iv), .in_ready(ir),
      .a(ra), .b(rb), .out_valid(ov), .out_ready(ordy),
      .p(rp), .busy(bz)
    );

    initial begin
      logic [2*W-1:0] q[$];
      logic [2*W-1:0] exp_p;
      int sent, got, cyc, pick;
      bit pending;
      sent = 0; got = 0; cyc = 0; pending = 1'b0;
      iv = 1'b0; ordy = 1'b0; ra = '0; rb = '0;
      while (r_rst) @(negedge clk);
      while (got < N_RND && cyc < BUDGET) begin
        @(negedge clk);
        cyc++;
        if (!pending) begin
          iv = (sent < N_RND) && ($urandom_range(0, 3) != 0);
          pick = $urandom_range(0, 7);
          ra = (pick == 0) ? '0 : (pick == 1) ? '1 : W'($urandom);
          pick = $urandom_range(0, 7);
          rb = (pick == 0) ? '0 : (pick == 1) ? '1 : W'($urandom);
        end
        ordy = ($urandom_range(0, 2) != 0);
        #1;
        if (ov && ordy) begin
          check($sformatf("rnd_w%0d_result_expected", W), 64'(q.size() > 0), 64'd1);
          if (q.size() > 0) begin
            exp_p = q.pop_front();
            check($sformatf("rnd_w%0d_p", W), 64'(rp), 64'(exp_p));
          end
          got++;
        end
        if (iv && ir) begin
          q.push_back({{W{1'b0}}, ra} * {{W{1'b0}}, rb});
          sent++;
          pending = 1'b0;
        end else begin
          pending = iv;
        end
      end
      check($sformatf("rnd_w%0d_results_seen", W), 64'(got), 64'(N_RND));
      check($sformatf("rnd_w%0d_queue_left", W), 64'(q.size()), 64'd0);
      @(negedge clk);
      iv = 1'b0;
      ordy = 1'b0;
      rnd_done[gi] = 1'b1;
    end
  end

  // One operation on the WIDTH=8 DUT with out_ready held high. lat counts
  // rising edges after the accept edge until out_valid is seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p_got, output int lat);
    int n;
    @(negedge clk);
    d_in_valid = 1'b1; d_a = a; d_b = b; d_out_ready = 1'b1;
    #1;
    n = 0;
    while (!d_in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("run8_ready_wait", 64'(d_in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    d_in_valid = 1'b0; d_a = 8'($urandom); d_b = 8'($urandom);
    #1;
    lat = 0;
    while (!d_out_valid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    p_got = d_p;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  initial begin
    vec_t        tbl [7];
    logic [15:0] pg;
    int          lat, exp_lat, n;
    bit          all_done;

    tbl[0] = '{8'h12, 8'h34, 16'h03A8};
    tbl[1] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[2] = '{8'h00, 8'h7F, 16'h0000};
    tbl[3] = '{8'h03, 8'h05, 16'h000F};
    tbl[4] = '{8'h80, 8'h80, 16'h4000};
    tbl[5] = '{8'h0F, 8'h11, 16'h00FF};
    tbl[6] = '{8'hA5, 8'h00, 16'h0000};

    d_in_valid = 1'b0; d_out_ready = 1'b0; d_a = '0; d_b = '0;
    e_in_valid = 1'b0; e_out_ready = 1'b0; e_a = '0; e_b = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(d_in_ready), 64'd0);
    check("rst_out_valid", 64'(d_out_valid), 64'd0);
    check("rst_p", 64'(d_p), 64'd0);
    check("rst_busy", 64'(d_busy), 64'd0);
    @(negedge clk);
    d_rst = 1'b0; e_rst = 1'b0; r_rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(d_in_ready), 64'd1);

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      exp_lat = (ZERO_SKIP && (tbl[i].a == 0 || tbl[i].b == 0)) ? 0 : 4;
      run8(tbl[i].a, tbl[i].b, pg, lat);
      check($sformatf("vec%0d_p", i), 64'(pg), 64'(tbl[i].p));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
      check($sformatf("vec%0d_busy_done", i), 64'(d_busy), 64'd1);
      @(negedge clk); #1;
      check($sformatf("vec%0d_idle_out_valid", i), 64'(d_out_valid), 64'd0);
      check($sformatf("vec%0d_idle_in_ready", i), 64'(d_in_ready), 64'd1);
    end

    // Backpressure, then same-edge retire and accept.
    @(negedge clk);
    d_in_valid = 1'b1; d_a = 8'h0F; d_b = 8'h11; d_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d_in_valid = 1'b0;
    #1;
    lat = 0;
    while (!d_out_valid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    check("bp_latency", 64'(lat), 64'd4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      d_in_valid = 1'b1; d_a = 8'h02; d_b = 8'h03;
      #1;
      check($sformatf("bp_hold%0d_out_valid", c), 64'(d_out_valid), 64'd1);
      check($sformatf("bp_hold%0d_p", c), 64'(d_p), 64'h00FF);
      check($sformatf("bp_hold%0d_in_ready", c), 64'(d_in_ready), 64'd0);
    end
    @(negedge clk);
    d_out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 64'(d_in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    d_in_valid = 1'b0;
    #1;
    check("b2b_out_valid_dropped", 64'(d_out_valid), 64'd0);
    check("b2b_busy", 64'(d_busy), 64'd1);
    lat = 0;
    while (!d_out_valid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    check("b2b_latency", 64'(lat), 64'd4);
    check("b2b_p", 64'(d_p), 64'h0006);
    @(negedge clk);

    // Reset two cycles into an operation.
    @(negedge clk);
    d_in_valid = 1'b1; d_a = 8'hAB; d_b = 8'hCD; d_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    d_rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(d_out_valid), 64'd0);
    check("midrst_p", 64'(d_p), 64'd0);
    check("midrst_busy", 64'(d_busy), 64'd0);
    check("midrst_in_ready", 64'(d_in_ready), 64'd0);
    repeat (2) @(negedge clk);
    d_rst = 1'b0;
    #1;
    check("midrst_release_in_ready", 64'(d_in_ready), 64'd1);
    run8(8'h03, 8'h05, pg, lat);
    check("midrst_next_p", 64'(pg), 64'h000F);
    check("midrst_next_latency", 64'(lat), 64'd4);
    @(negedge clk);

    // WIDTH=16 full-scale product.
    @(negedge clk);
    e_in_valid = 1'b1; e_a = 16'hFFFF; e_b = 16'hFFFF; e_out_ready = 1'b1;
    #1;
    check("w16_in_ready", 64'(e_in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    e_in_valid = 1'b0;
    #1;
    lat = 0;
    while (!e_out_valid && lat < 60) begin
      @(negedge clk); #1; lat++;
    end
    check("w16_latency", 64'(lat), 64'd16);
    check("w16_p", 64'(e_p), 64'hFFFE0001);

    // Wait for the randomized streams.
    n = 0;
    all_done = 1'b0;
    while (!all_done && n < BUDGET + 1000) begin
      @(negedge clk);
      n++;
      all_done = rnd_done[0] && rnd_done[1] && rnd_done[2] && rnd_done[3];
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("rnd%0d_finished", i), 64'(rnd_done[i]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
